// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, even parity, one stop bit.
// Oversampled mid-bit sampling, with a one-clock valid strobe and error flags.
module uart_rx #(
  parameter int unsigned p_clk_freq   = 50_000_000,
  parameter int unsigned p_baud_freq  = 115_200,
  parameter int unsigned p_oversample = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_parity_err,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int unsigned DIV_RAW = p_clk_freq / (p_baud_freq * p_oversample);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TCK_W   = $clog2(p_oversample);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TCK_W-1:0] HALF_LAST = TCK_W'(p_oversample / 2 - 1);
  localparam logic [TCK_W-1:0] FULL_LAST = TCK_W'(p_oversample - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_e;

  state_e state_q, state_d;

  logic             rx_meta_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TCK_W-1:0] tck_q, tck_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [7:0]       data_q, data_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             valid_q, valid_d;

  logic tick;
  logic bit_done;

  assign tick     = (div_q == DIV_LAST);
  // The start bit is sampled after half a bit; every later bit a full bit after that.
  assign bit_done = tick && (tck_q == ((state_q == S_START) ? HALF_LAST : FULL_LAST));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!rx_s_q) state_d = S_START;
      S_START:  if (bit_done) state_d = rx_s_q ? S_IDLE : S_DATA;
      S_DATA:   if (bit_done && idx_q == 3'd7) state_d = S_PARITY;
      S_PARITY: if (bit_done) state_d = S_STOP;
      S_STOP:   if (bit_done) state_d = rx_s_q ? S_IDLE : S_BREAK;
      S_BREAK:  if (rx_s_q) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  always_comb begin
    div_d   = tick ? '0 : div_q + 1'b1;
    tck_d   = tck_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    valid_d = 1'b0;
    if (tick) tck_d = bit_done ? '0 : tck_q + 1'b1;
    case (state_q)
      S_IDLE: if (!rx_s_q) begin
        div_d = '0;
        tck_d = '0;
        idx_d = '0;
      end
      S_DATA: if (bit_done) begin
        shift_d[idx_q] = rx_s_q;
        idx_d          = idx_q + 1'b1;
      end
      S_PARITY: if (bit_done) par_d = rx_s_q;
      S_STOP: if (bit_done) begin
        data_d  = shift_q;
        perr_d  = par_q ^ (^shift_q);
        ferr_d  = !rx_s_q;
        valid_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_q   <= '0;
      tck_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      tck_q   <= tck_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      valid_q <= valid_d;
    end
  end

  assign o_data       = data_q;
  assign o_valid      = valid_q;
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, the far end of the team's UART transmitter.
- Frame format is fixed: 1 start bit (low), 8 data bits LSB first, 1 even-parity bit, 1 stop bit (high).
- Parity bit = XOR of the 8 data bits.
- Oversamples the serial line, recovers bytes, and presents each byte with a one-clock valid strobe plus parity and framing status to the downstream consumer (FIFO or register interface).

Parameters:
- p_clk_freq, 50_000_000, system clock frequency in Hz.
- p_baud_freq, 115_200, line baud rate in Hz.
- p_oversample, 16, sample ticks per bit period. Must be even and >= 4.

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- i_rx  input  1  serial line, asynchronous to i_clk, idles high.
- o_data  output  8  last received byte.
- o_valid  output  1  one-clock pulse when o_data and status are updated.
- o_parity_err  output  1  parity mismatch on the last frame.
- o_frame_err  output  1  stop bit sampled low on the last frame.
- o_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-high.
  - i_rst=1 forces: FSM to IDLE, o_data=0, o_valid=0, o_parity_err=0, o_frame_err=0, o_busy=0, all counters to 0, synchronizer flops to 1.
  - Reset mid-frame abandons the frame with no o_valid.
- Synchronizer: i_rx passes through a 2-flop synchronizer. All decisions use the synchronized value (rx_s).
- Tick generator:
  - Divisor D = p_clk_freq / (p_baud_freq*p_oversample), integer-truncated, minimum 1.
  - Counter emits a one-clock tick every D clocks.
  - Counter free-runs and is restarted on start-edge detection, so tick phase aligns to the start edge.
- Per-bit counter: a tick counter (0..p_oversample-1) tracks the position within each bit.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: on rx_s falling to 0, clear counters and go to START.
  - START: after p_oversample/2 ticks (mid start bit), sample rx_s.
    - If 1: glitch; return to IDLE, no output.
    - If 0: go to DATA with bit index 0.
  - DATA: every p_oversample ticks, sample rx_s into shift bit [index] (LSB first). After index 7, go to PARITY.
  - PARITY: after p_oversample ticks, sample the parity bit and go to STOP.
  - STOP: after p_oversample ticks, sample the stop bit.
    - On the next clock: o_data = assembled byte, o_parity_err = (parity_bit != ^byte), o_frame_err = (stop==0), o_valid=1 for exactly one clock.
    - If stop==1: return to IDLE.
    - If stop==0: go to BREAK.
  - BREAK: wait until rx_s==1, then IDLE. No new frame is detected while the line is held low.
- Data on error: the byte is delivered even on parity/frame error. The error flags qualify it.
- Output hold: o_data, o_parity_err and o_frame_err hold until the next o_valid. Each o_valid overwrites both flags.
- o_busy: =1 in every state except IDLE.
- Latency: o_valid rises 1 clock after the mid-stop-bit sample, i.e. ~10.5 bit periods + 2 synchronizer clocks + 1 after the start edge.
- Back-to-back frames: a start edge arriving immediately after the stop bit (IDLE re-entered) must be accepted. No idle gap is required beyond the stop bit.
- Baud tolerance: sampling at mid-bit tolerates ±(50/10.5)% cumulative baud mismatch. No further correction is applied.

Test Plan (p_clk_freq=3_200_000, p_baud_freq=100_000, p_oversample=16 -> D=2, 32 clocks/bit):
- Reset: assert i_rst mid-frame (during DATA bit 3), release, keep i_rx=1 -> o_valid never pulses, o_busy=0, o_data=0x00, flags 0.
- Good frame: send 0xA5 with parity 0, stop 1 -> single o_valid pulse, o_data=0xA5, o_parity_err=0, o_frame_err=0, o_busy drops after stop.
- Parity error: send 0x01 with parity bit 0 -> o_data=0x01, o_parity_err=1, o_frame_err=0.
- Framing/break: send 0x3C, stop bit 0, hold line low 5 bit periods, then high, then send 0x55 correctly:
  - first o_valid: o_frame_err=1.
  - no frames detected while low.
  - second o_valid: 0x55 with both flags 0.
- Glitch rejection: pulse i_rx low for 4 clocks (<half bit) -> FSM returns to IDLE, no o_valid.
- Back-to-back: send 0x00, 0xFF, 0x81 with no idle gap -> three o_valid pulses, exactly 11 bit periods (352 clocks) apart, data in order, all flags 0.
